// File: rtl/ifu_pcgen.sv
// Fetch PC generator with in-flight address tracking, redirect-drop accounting
// and a small {pc, ir} buffer feeding decode over a val/rdy handshake.
module ifu_pcgen #(
  parameter logic [31:0] RESET_PC  = 32'h8000_0000,
  parameter int unsigned MAX_OUTS  = 2,
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_setpc,
  input  logic [31:0] i_newpc,
  output logic        hs_if4mem_val,
  input  logic        hs_mem4if_rdy,
  output logic [31:0] o_mem_addr,
  input  logic        i_mem_rvld,
  input  logic [31:0] i_mem_rdata,
  output logic        hs_if4de_val,
  input  logic        hs_de4if_rdy,
  output logic [31:0] o_ir,
  output logic [31:0] o_pc
);

  localparam int unsigned OW  = $clog2(MAX_OUTS + 1);
  localparam int unsigned QAW = (MAX_OUTS > 1) ? $clog2(MAX_OUTS) : 1;
  localparam int unsigned BAW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int unsigned BCW = $clog2(BUF_DEPTH + 1);

  logic [31:0]    pc_q, pc_d;
  logic [OW-1:0]  outs_q, outs_d;
  logic [OW-1:0]  drop_q, drop_d;
  logic           go_q, go_d;
  logic [QAW-1:0] q_wr_q, q_wr_d, q_rd_q, q_rd_d;
  logic [BAW-1:0] buf_wr_q, buf_wr_d, buf_rd_q, buf_rd_d;
  logic [BCW-1:0] buf_cnt_q, buf_cnt_d;

  logic [31:0] inf_addr_q [MAX_OUTS];
  logic [31:0] inf_addr_d [MAX_OUTS];
  logic [31:0] buf_pc_q [BUF_DEPTH];
  logic [31:0] buf_pc_d [BUF_DEPTH];
  logic [31:0] buf_ir_q [BUF_DEPTH];
  logic [31:0] buf_ir_d [BUF_DEPTH];

  logic          req_fire, de_fire, rsp_ok, keep;
  logic          outs_ok, credit_ok;
  logic [OW-1:0] live;

  function automatic logic [QAW-1:0] q_inc(input logic [QAW-1:0] p);
    return (32'(p) == MAX_OUTS - 1) ? '0 : p + QAW'(1);
  endfunction

  function automatic logic [BAW-1:0] b_inc(input logic [BAW-1:0] p);
    return (32'(p) == BUF_DEPTH - 1) ? '0 : p + BAW'(1);
  endfunction

  // Credit counts live (non-dropped) requests so every live response has a buffer slot.
  always_comb begin
    live      = outs_q - drop_q;
    outs_ok   = 32'(outs_q) < MAX_OUTS;
    credit_ok = (32'(live) + 32'(buf_cnt_q)) < BUF_DEPTH;

    hs_if4mem_val = go_q & ~i_setpc & outs_ok & credit_ok;
    hs_if4de_val  = (buf_cnt_q != '0) & ~i_setpc;
    o_mem_addr    = pc_q;
    o_pc          = buf_pc_q[buf_rd_q];
    o_ir          = buf_ir_q[buf_rd_q];

    req_fire = hs_if4mem_val & hs_mem4if_rdy;
    de_fire  = hs_if4de_val & hs_de4if_rdy;
    rsp_ok   = i_mem_rvld & (outs_q != '0);
    keep     = rsp_ok & (drop_q == '0) & ~i_setpc;
  end

  always_comb begin
    pc_d       = pc_q;
    outs_d     = outs_q + OW'(req_fire) - OW'(rsp_ok);
    drop_d     = drop_q;
    go_d       = 1'b1;
    q_wr_d     = q_wr_q;
    q_rd_d     = q_rd_q;
    buf_wr_d   = buf_wr_q;
    buf_rd_d   = buf_rd_q;
    buf_cnt_d  = buf_cnt_q;
    inf_addr_d = inf_addr_q;
    buf_pc_d   = buf_pc_q;
    buf_ir_d   = buf_ir_q;

    if (req_fire) begin
      inf_addr_d[q_wr_q] = pc_q;
    end
    if (keep) begin
      buf_pc_d[buf_wr_q] = inf_addr_q[q_rd_q];
      buf_ir_d[buf_wr_q] = i_mem_rdata;
    end

    if (i_setpc) begin
      // Every request still pending after this cycle belongs to the old stream.
      pc_d      = {i_newpc[31:2], 2'b00};
      drop_d    = outs_q - OW'(rsp_ok);
      q_wr_d    = '0;
      q_rd_d    = '0;
      buf_wr_d  = '0;
      buf_rd_d  = '0;
      buf_cnt_d = '0;
    end else begin
      if (req_fire) begin
        pc_d   = pc_q + 32'd4;
        q_wr_d = q_inc(q_wr_q);
      end
      if (rsp_ok && drop_q != '0) begin
        drop_d = drop_q - OW'(1);
      end
      if (keep) begin
        q_rd_d   = q_inc(q_rd_q);
        buf_wr_d = b_inc(buf_wr_q);
      end
      if (de_fire) begin
        buf_rd_d = b_inc(buf_rd_q);
      end
      buf_cnt_d = buf_cnt_q + BCW'(keep) - BCW'(de_fire);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q      <= RESET_PC;
      outs_q    <= '0;
      drop_q    <= '0;
      go_q      <= 1'b0;
      q_wr_q    <= '0;
      q_rd_q    <= '0;
      buf_wr_q  <= '0;
      buf_rd_q  <= '0;
      buf_cnt_q <= '0;
    end else begin
      pc_q      <= pc_d;
      outs_q    <= outs_d;
      drop_q    <= drop_d;
      go_q      <= go_d;
      q_wr_q    <= q_wr_d;
      q_rd_q    <= q_rd_d;
      buf_wr_q  <= buf_wr_d;
      buf_rd_q  <= buf_rd_d;
      buf_cnt_q <= buf_cnt_d;
    end
  end

  // Storage arrays carry no reset; validity is tracked by the pointers above.
  always_ff @(posedge clk) begin
    inf_addr_q <= inf_addr_d;
    buf_pc_q   <= buf_pc_d;
    buf_ir_q   <= buf_ir_d;
  end

endmodule

// File: tb/tb_ifu_pcgen.sv
// Directed bench for ifu_pcgen: scripted memory model, expected-address and
// expected-decode queues checked by independent monitors.
module tb_ifu_pcgen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_setpc;
  logic [31:0] i_newpc;
  logic        hs_if4mem_val;
  logic        hs_mem4if_rdy;
  logic [31:0] o_mem_addr;
  logic        i_mem_rvld;
  logic [31:0] i_mem_rdata;
  logic        hs_if4de_val;
  logic        hs_de4if_rdy;
  logic [31:0] o_ir;
  logic [31:0] o_pc;

  int checks = 0;
  int errors = 0;
  int grant_total = 0;
  bit hold_rsp = 1'b0;
  logic [31:0] exp_addr [$];
  logic [31:0] exp_pc [$];

  ifu_pcgen dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_setpc      (i_setpc),
    .i_newpc      (i_newpc),
    .hs_if4mem_val(hs_if4mem_val),
    .hs_mem4if_rdy(hs_mem4if_rdy),
    .o_mem_addr   (o_mem_addr),
    .i_mem_rvld   (i_mem_rvld),
    .i_mem_rdata  (i_mem_rdata),
    .hs_if4de_val (hs_if4de_val),
    .hs_de4if_rdy (hs_de4if_rdy),
    .o_ir         (o_ir),
    .o_pc         (o_pc)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] data_of(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC0DE_F00D;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Memory: grants up to grant_total requests, answers one cycle later unless held.
  initial begin
    logic [31:0] pend [$];
    logic [31:0] a;
    logic [31:0] e;
    bit f, h, r;
    int granted, gt, outs_now;
    granted       = 0;
    hs_mem4if_rdy = 1'b0;
    i_mem_rvld    = 1'b0;
    i_mem_rdata   = '0;
    forever begin
      @(negedge clk);
      f  = (hs_if4mem_val === 1'b1) && hs_mem4if_rdy;
      a  = o_mem_addr;
      h  = hold_rsp;
      r  = rst_n;
      gt = grant_total;
      if (f && r) begin
        outs_now = pend.size() + (i_mem_rvld ? 1 : 0);
        chk("outs_limit", 32'(outs_now < 2), 32'd1);
        if (exp_addr.size() == 0) begin
          chk("req_extra", a, 32'hxxxx_xxxx);
        end else begin
          e = exp_addr.pop_front();
          chk("req_addr", a, e);
        end
      end
      @(posedge clk);
      #1;
      if (!r) begin
        pend.delete();
      end else if (f) begin
        pend.push_back(a);
        granted++;
      end
      if (r && !h && pend.size() > 0) begin
        i_mem_rvld  = 1'b1;
        i_mem_rdata = data_of(pend.pop_front());
      end else begin
        i_mem_rvld  = 1'b0;
      end
      hs_mem4if_rdy = granted < gt;
    end
  end

  // Decode monitor.
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (hs_if4de_val === 1'b1 && hs_de4if_rdy) begin
        if (exp_pc.size() == 0) begin
          chk("de_extra", o_pc, 32'hxxxx_xxxx);
        end else begin
          e = exp_pc.pop_front();
          chk("de_pc", o_pc, e);
          chk("de_ir", o_ir, data_of(e));
        end
      end
    end
  end

  initial begin
    rst_n        = 1'b0;
    i_setpc      = 1'b0;
    i_newpc      = '0;
    hs_de4if_rdy = 1'b0;
    step(3);
    @(negedge clk);
    chk("rst_mem_val", 32'(hs_if4mem_val), 32'd0);
    chk("rst_de_val", 32'(hs_if4de_val), 32'd0);

    // 1: streaming fetch from reset PC
    exp_addr.push_back(32'h8000_0000); exp_addr.push_back(32'h8000_0004);
    exp_addr.push_back(32'h8000_0008);
    exp_pc.push_back(32'h8000_0000); exp_pc.push_back(32'h8000_0004);
    exp_pc.push_back(32'h8000_0008);
    step(1);
    rst_n        = 1'b1;
    hs_de4if_rdy = 1'b1;
    grant_total += 3;
    step(14);

    // 2: decode stalled, buffer fills to two then resumes
    exp_addr.push_back(32'h8000_000C); exp_addr.push_back(32'h8000_0010);
    exp_addr.push_back(32'h8000_0014); exp_addr.push_back(32'h8000_0018);
    exp_pc.push_back(32'h8000_000C); exp_pc.push_back(32'h8000_0010);
    exp_pc.push_back(32'h8000_0014); exp_pc.push_back(32'h8000_0018);
    hs_de4if_rdy = 1'b0;
    grant_total += 4;
    step(8);
    @(negedge clk);
    chk("full_mem_val", 32'(hs_if4mem_val), 32'd0);
    chk("full_de_val", 32'(hs_if4de_val), 32'd1);
    chk("full_head_pc", o_pc, 32'h8000_000C);
    chk("full_head_ir", o_ir, data_of(32'h8000_000C));
    step(1);
    hs_de4if_rdy = 1'b1;
    step(14);

    // 3: redirect with two requests outstanding
    exp_addr.push_back(32'h8000_001C); exp_addr.push_back(32'h8000_0020);
    exp_addr.push_back(32'h0000_1000); exp_addr.push_back(32'h0000_1004);
    exp_pc.push_back(32'h0000_1000); exp_pc.push_back(32'h0000_1004);
    hold_rsp     = 1'b1;
    grant_total += 2;
    step(6);
    i_setpc = 1'b1;
    i_newpc = 32'h0000_1003;
    @(negedge clk);
    chk("t3_setpc_mem_val", 32'(hs_if4mem_val), 32'd0);
    step(1);
    i_setpc      = 1'b0;
    hold_rsp     = 1'b0;
    grant_total += 2;
    step(14);

    // 4: redirect coincides with a response and a pending request
    exp_addr.push_back(32'h0000_1008);
    exp_addr.push_back(32'h0000_3000); exp_addr.push_back(32'h0000_3004);
    exp_pc.push_back(32'h0000_3000); exp_pc.push_back(32'h0000_3004);
    grant_total += 1;
    step(2);
    i_setpc = 1'b1;
    i_newpc = 32'h0000_3000;
    @(negedge clk);
    chk("t4_setpc_mem_val", 32'(hs_if4mem_val), 32'd0);
    chk("t4_setpc_de_val", 32'(hs_if4de_val), 32'd0);
    step(1);
    i_setpc      = 1'b0;
    grant_total += 2;
    step(14);

    // 5: back-to-back redirects, the later one wins
    exp_addr.push_back(32'h0000_3008);
    exp_addr.push_back(32'h0000_0200); exp_addr.push_back(32'h0000_0204);
    exp_pc.push_back(32'h0000_0200); exp_pc.push_back(32'h0000_0204);
    hs_de4if_rdy = 1'b0;
    grant_total += 1;
    step(6);
    i_setpc = 1'b1;
    i_newpc = 32'h0000_0100;
    @(negedge clk);
    chk("t5_setpc1_de_val", 32'(hs_if4de_val), 32'd0);
    step(1);
    i_newpc      = 32'h0000_0200;
    grant_total += 2;
    @(negedge clk);
    chk("t5_setpc2_de_val", 32'(hs_if4de_val), 32'd0);
    step(1);
    i_setpc      = 1'b0;
    hs_de4if_rdy = 1'b1;
    step(14);

    // 6: PC wrap, then mid-stream reset
    exp_addr.push_back(32'hFFFF_FFFC); exp_addr.push_back(32'h0000_0000);
    exp_addr.push_back(32'h0000_0004); exp_addr.push_back(32'h0000_0008);
    exp_addr.push_back(32'h8000_0000);
    exp_pc.push_back(32'hFFFF_FFFC); exp_pc.push_back(32'h0000_0000);
    exp_pc.push_back(32'h8000_0000);
    i_setpc      = 1'b1;
    i_newpc      = 32'hFFFF_FFFC;
    grant_total += 2;
    step(1);
    i_setpc = 1'b0;
    step(12);
    hs_de4if_rdy = 1'b0;
    grant_total += 2;
    step(8);
    rst_n = 1'b0;
    step(1);
    @(negedge clk);
    chk("midrst_mem_val", 32'(hs_if4mem_val), 32'd0);
    chk("midrst_de_val", 32'(hs_if4de_val), 32'd0);
    step(1);
    rst_n        = 1'b1;
    hs_de4if_rdy = 1'b1;
    grant_total += 1;
    step(20);

    chk("addr_queue_drained", 32'(exp_addr.size()), 32'd0);
    chk("pc_queue_drained", 32'(exp_pc.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
